cnt_seq_ctl: RTL and testbench



---
 rtl/cnt_seq_ctl.sv | 143 ++++++++++++++
 tb/tb_cnt_seq_ctl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctl.sv
// cnt_seq_ctl: controller for one down-counter channel.
//   Latches a configuration on start, loads the counter (cnt_baz/cnt_turn),
//   selects its mode (cnt_bar) and feeds it a prescaled decrement strobe
//   (cnt_blrb). Each expiry flag (cnt_cwm) is acknowledged by holding the
//   active-low clear (cnt_zz1pb) low until the flag drops. Expiries are
//   counted (evt_count), and the run ends after cfg_events expiries (0 = never).
// Ports:
//   sysclk, foo_card_n      clock (rising edge), synchronous active-low reset
//   start, stop             one-cycle command pulses
//   cfg_turn/bar/events/presc  configuration, latched on an accepted start
//   cnt_baz/turn/bar/blrb/zz1pb  counter-channel controls
//   cnt_cwm                 counter expiry flag
//   busy, done, evt_count   status
module cnt_seq_ctl #(
  parameter int unsigned TURN_W  = 32,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned EVT_W   = 16
) (
  input  logic               sysclk,
  input  logic               foo_card_n,
  input  logic               start,
  input  logic               stop,
  input  logic [TURN_W-1:0]  cfg_turn,
  input  logic               cfg_bar,
  input  logic [EVT_W-1:0]   cfg_events,
  input  logic [PRESC_W-1:0] cfg_presc,
  output logic               cnt_baz,
  output logic [TURN_W-1:0]  cnt_turn,
  output logic               cnt_bar,
  output logic               cnt_blrb,
  output logic               cnt_zz1pb,
  input  logic               cnt_cwm,
  output logic               busy,
  output logic               done,
  output logic [EVT_W-1:0]   evt_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_ACK,
    S_FINISH,
    S_ABORT
  } state_e;

  state_e             state_q, state_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               bar_q, bar_d;
  logic [EVT_W-1:0]   events_q, events_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] psc_q, psc_d;
  logic               blrb_q, blrb_d;
  logic [EVT_W-1:0]   evt_q, evt_d;

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    bar_d    = bar_q;
    events_d = events_q;
    presc_d  = presc_q;
    psc_d    = psc_q;
    blrb_d   = 1'b0;
    evt_d    = evt_q;

    unique case (state_q)
      S_IDLE: begin
        // stop takes priority over start in IDLE
        if (start && !stop) begin
          turn_d   = cfg_turn;
          bar_d    = cfg_bar;
          events_d = cfg_events;
          presc_d  = cfg_presc;
          evt_d    = '0;
          state_d  = (cfg_turn == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        psc_d   = '0;
        state_d = stop ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_ABORT;
        end else if (cnt_cwm) begin
          // no strobe and no prescaler advance in the cycle the flag is seen
          state_d = S_ACK;
          if (evt_q != '1) evt_d = evt_q + 1'b1;
        end else if (psc_q == presc_q) begin
          psc_d  = '0;
          blrb_d = 1'b1;
        end else begin
          psc_d = psc_q + 1'b1;
        end
      end
      S_ACK: begin
        // prescaler stays frozen here so auto-reload resumes where it left off
        if (stop) begin
          state_d = S_ABORT;
        end else if (!cnt_cwm) begin
          if ((events_q != '0) && (evt_q == events_q)) state_d = S_FINISH;
          else if (bar_q)                              state_d = S_RUN;
          else                                         state_d = S_LOAD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!foo_card_n) begin
      state_q  <= S_IDLE;
      turn_q   <= '0;
      bar_q    <= 1'b0;
      events_q <= '0;
      presc_q  <= '0;
      psc_q    <= '0;
      blrb_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      bar_q    <= bar_d;
      events_q <= events_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      blrb_q   <= blrb_d;
      evt_q    <= evt_d;
    end
  end

  assign cnt_baz   = (state_q == S_LOAD);
  assign cnt_turn  = turn_q;
  assign cnt_bar   = bar_q;
  assign cnt_blrb  = blrb_q;
  assign cnt_zz1pb = !((state_q == S_ACK) || (state_q == S_ABORT));
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign evt_count = evt_q;

endmodule

// File: tb/tb_cnt_seq_ctl.sv
// Bench for cnt_seq_ctl: a behavioural counter-bank model answers the
// controller, and per-run statistics (loads, strobe spacing, clear episodes,
// done pulses) are compared with what the configuration implies.
module tb_cnt_seq_ctl;
  localparam int TURN_W  = 32;
  localparam int PRESC_W = 16;
  localparam int EVT_W   = 16;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic               foo_card_n = 1'b0;
  logic               start = 1'b0, stop = 1'b0, cfg_bar = 1'b0, cnt_cwm = 1'b0;
  logic [TURN_W-1:0]  cfg_turn = '0;
  logic [EVT_W-1:0]   cfg_events = '0;
  logic [PRESC_W-1:0] cfg_presc = '0;
  logic               cnt_baz, cnt_bar, cnt_blrb, cnt_zz1pb, busy, done;
  logic [TURN_W-1:0]  cnt_turn;
  logic [EVT_W-1:0]   evt_count;
  logic               s_baz, s_bar, s_blrb, s_zz1pb, s_busy, s_done;
  logic [TURN_W-1:0]  s_turn;
  logic [1:0]         evt_count_s;

  cnt_seq_ctl #(.TURN_W(TURN_W), .PRESC_W(PRESC_W), .EVT_W(EVT_W)) dut (
    .sysclk(sysclk), .foo_card_n(foo_card_n), .start(start), .stop(stop),
    .cfg_turn(cfg_turn), .cfg_bar(cfg_bar), .cfg_events(cfg_events), .cfg_presc(cfg_presc),
    .cnt_baz(cnt_baz), .cnt_turn(cnt_turn), .cnt_bar(cnt_bar), .cnt_blrb(cnt_blrb),
    .cnt_zz1pb(cnt_zz1pb), .cnt_cwm(cnt_cwm), .busy(busy), .done(done), .evt_count(evt_count));

  // narrow expiry counter to reach saturation quickly
  cnt_seq_ctl #(.TURN_W(TURN_W), .PRESC_W(PRESC_W), .EVT_W(2)) dut_s (
    .sysclk(sysclk), .foo_card_n(foo_card_n), .start(start), .stop(stop),
    .cfg_turn(cfg_turn), .cfg_bar(cfg_bar), .cfg_events(cfg_events[1:0]), .cfg_presc(cfg_presc),
    .cnt_baz(s_baz), .cnt_turn(s_turn), .cnt_bar(s_bar), .cnt_blrb(s_blrb),
    .cnt_zz1pb(s_zz1pb), .cnt_cwm(cnt_cwm), .busy(s_busy), .done(s_done), .evt_count(evt_count_s));

  int n_cmp = 0, n_err = 0;

  // counter-bank model
  int unsigned bank_cnt = 0, bank_turn = 0;
  bit          bank_bar = 1'b0;
  logic        p_baz = 1'b0, p_blrb = 1'b0, p_zz1pb = 1'b1;

  // run statistics
  int cyc = 0, anchor = 0, exp_gap = 0, cur_presc = 0;
  bit anc_v = 1'b0;
  int n_baz, n_done, n_lo_start, n_ack_ep, n_short_lo, blrb_bad, gap_bad, lo_len;

  task automatic clear_stats();
    n_baz = 0; n_done = 0; n_lo_start = 0; n_ack_ep = 0; n_short_lo = 0;
    blrb_bad = 0; gap_bad = 0; lo_len = 0; anc_v = 1'b0;
  endtask

  task automatic step();
    @(posedge sysclk); #1;
    cyc++;
    // bank registers what it saw during the previous cycle
    if (p_zz1pb === 1'b0) cnt_cwm = 1'b0;
    if (p_baz === 1'b1) bank_cnt = bank_turn;
    else if (p_blrb === 1'b1 && bank_cnt != 0) begin
      bank_cnt--;
      if (bank_cnt == 0) begin
        cnt_cwm = 1'b1;
        if (bank_bar) bank_cnt = bank_turn;
      end
    end
    p_baz = cnt_baz; p_blrb = cnt_blrb; p_zz1pb = cnt_zz1pb;
    if (cnt_baz === 1'b1) n_baz++;
    if (done === 1'b1) n_done++;
    if (cnt_zz1pb === 1'b0) begin
      if (lo_len == 0) n_lo_start++;
      lo_len++;
    end else if (lo_len > 0) begin
      if (lo_len >= 2) n_ack_ep++; else n_short_lo++;
      lo_len = 0;
    end
    if (cnt_blrb === 1'b1 && (cnt_zz1pb !== 1'b1 || busy !== 1'b1 || cnt_baz === 1'b1)) blrb_bad++;
    // strobe spacing: first strobe presc+2 after a load, then every presc+1
    if (cnt_zz1pb !== 1'b1 || busy !== 1'b1) anc_v = 1'b0;
    else if (cnt_baz === 1'b1) begin anc_v = 1'b1; anchor = cyc; exp_gap = cur_presc + 2; end
    else if (cnt_blrb === 1'b1) begin
      if (anc_v && (cyc - anchor) != exp_gap) gap_bad++;
      anc_v = 1'b1; anchor = cyc; exp_gap = cur_presc + 1;
    end else if (anc_v && (cyc - anchor) >= exp_gap) begin
      gap_bad++; anc_v = 1'b0;
    end
  endtask

  task automatic do_start(input int unsigned t, input bit b, input int unsigned e, input int unsigned p);
    cfg_turn = TURN_W'(t); cfg_bar = b; cfg_events = EVT_W'(e); cfg_presc = PRESC_W'(p);
    bank_turn = t; bank_bar = b; cur_presc = int'(p);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int k = 0;
    while (n_done == 0 && k < limit) begin step(); k++; end
    ok = (n_done > 0);
    step();
  endtask

  task automatic test_reset();
    bit reached = 1'b0;
    foo_card_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({cnt_baz, cnt_blrb, cnt_zz1pb, cnt_bar, busy, done} !== 6'b001000 || evt_count !== '0 || cnt_turn !== '0) begin
      n_err++; $display("FAIL reset_por: ctl=%b evt=%0d turn=%0d want ctl=001000 evt=0 turn=0",
                        {cnt_baz, cnt_blrb, cnt_zz1pb, cnt_bar, busy, done}, evt_count, cnt_turn);
    end
    foo_card_n = 1'b1;
    step();
    clear_stats();
    do_start(2, 1'b1, 0, 1);
    for (int i = 0; i < 300 && !reached; i++) begin
      step();
      if (n_lo_start >= 1 && cnt_zz1pb === 1'b1 && busy === 1'b1) reached = 1'b1;
    end
    n_cmp++;
    if (!reached) begin n_err++; $display("FAIL reset_reach_run: got timeout want RUN after expiry"); end
    foo_card_n = 1'b0;
    step();
    n_cmp++;
    if ({cnt_baz, cnt_blrb, cnt_zz1pb, cnt_bar, busy, done} !== 6'b001000 || evt_count !== '0 || cnt_turn !== '0) begin
      n_err++; $display("FAIL reset_midrun: ctl=%b evt=%0d turn=%0d want ctl=001000 evt=0 turn=0",
                        {cnt_baz, cnt_blrb, cnt_zz1pb, cnt_bar, busy, done}, evt_count, cnt_turn);
    end
    step();
    n_cmp++;
    if (cnt_zz1pb !== 1'b1 || busy !== 1'b0 || lo_len != 0) begin
      n_err++; $display("FAIL reset_no_clear: zz1pb=%b busy=%b want zz1pb=1 busy=0", cnt_zz1pb, busy);
    end
    foo_card_n = 1'b1;
    cnt_cwm = 1'b0; bank_cnt = 0;
    step();
  endtask

  task automatic test_one_shot();
    bit ok;
    clear_stats();
    do_start(3, 1'b0, 2, 1);
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL one_shot_done: got timeout want done"); end
    n_cmp++; if (n_baz != 2) begin n_err++; $display("FAIL one_shot_loads: got %0d want 2", n_baz); end
    n_cmp++; if (n_ack_ep != 2 || n_short_lo != 0) begin
      n_err++; $display("FAIL one_shot_acks: got %0d long/%0d short want 2/0", n_ack_ep, n_short_lo); end
    n_cmp++; if (gap_bad != 0 || blrb_bad != 0) begin
      n_err++; $display("FAIL one_shot_strobe: got gap_bad=%0d blrb_bad=%0d want 0/0", gap_bad, blrb_bad); end
    n_cmp++; if (evt_count !== EVT_W'(2) || n_done != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL one_shot_end: got evt=%0d done=%0d busy=%b want 2/1/0", evt_count, n_done, busy); end
    n_cmp++; if (cnt_bar !== 1'b0 || cnt_turn !== TURN_W'(3)) begin
      n_err++; $display("FAIL one_shot_shadow: got bar=%b turn=%0d want 0/3", cnt_bar, cnt_turn); end
  endtask

  // auto-reload run with an ignored start carrying different cfg mid-run
  task automatic test_auto_reload();
    bit ok;
    clear_stats();
    do_start(2, 1'b1, 3, 0);
    step(); step(); step();
    cfg_turn = TURN_W'(9); cfg_bar = 1'b0; cfg_events = EVT_W'(1); cfg_presc = PRESC_W'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (cnt_turn !== TURN_W'(2) || cnt_bar !== 1'b1) begin
      n_err++; $display("FAIL auto_shadow_midrun: got turn=%0d bar=%b want 2/1", cnt_turn, cnt_bar); end
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL auto_done: got timeout want done"); end
    n_cmp++; if (n_baz != 1) begin n_err++; $display("FAIL auto_loads: got %0d want 1", n_baz); end
    n_cmp++; if (n_ack_ep != 3 || n_short_lo != 0) begin
      n_err++; $display("FAIL auto_acks: got %0d long/%0d short want 3/0", n_ack_ep, n_short_lo); end
    n_cmp++; if (gap_bad != 0 || blrb_bad != 0) begin
      n_err++; $display("FAIL auto_strobe: got gap_bad=%0d blrb_bad=%0d want 0/0", gap_bad, blrb_bad); end
    n_cmp++; if (evt_count !== EVT_W'(3) || n_done != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL auto_end: got evt=%0d done=%0d busy=%b want 3/1/0", evt_count, n_done, busy); end
  endtask

  // run-forever; stop lands in the same cycle the flag is seen
  task automatic test_stop();
    bit reached = 1'b0;
    int ev_exp;
    clear_stats();
    do_start(1, 1'b1, 0, 0);
    for (int i = 0; i < 500 && !reached; i++) begin
      step();
      if (n_lo_start >= 5 && cnt_cwm === 1'b1 && cnt_zz1pb === 1'b1 && busy === 1'b1 && cnt_baz === 1'b0)
        reached = 1'b1;
    end
    n_cmp++; if (!reached) begin n_err++; $display("FAIL stop_reach: got timeout want 5 expiries"); end
    ev_exp = n_lo_start;
    n_cmp++; if (evt_count !== EVT_W'(ev_exp)) begin
      n_err++; $display("FAIL stop_counting: got %0d want %0d", evt_count, ev_exp); end
    n_cmp++; if (evt_count_s !== 2'd3) begin
      n_err++; $display("FAIL stop_saturate: got %0d want 3", evt_count_s); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if (cnt_zz1pb !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || evt_count !== EVT_W'(ev_exp)) begin
      n_err++; $display("FAIL stop_abort: got zz1pb=%b busy=%b done=%b evt=%0d want 0/1/0/%0d",
                        cnt_zz1pb, busy, done, evt_count, ev_exp); end
    step();
    n_cmp++; if (cnt_zz1pb !== 1'b1 || busy !== 1'b0 || evt_count !== EVT_W'(ev_exp)) begin
      n_err++; $display("FAIL stop_idle: got zz1pb=%b busy=%b evt=%0d want 1/0/%0d", cnt_zz1pb, busy, evt_count, ev_exp); end
    step(); step();
    n_cmp++; if (n_done != 0 || n_short_lo != 1 || evt_count !== EVT_W'(ev_exp)) begin
      n_err++; $display("FAIL stop_hold: got done=%0d short_lo=%0d evt=%0d want 0/1/%0d", n_done, n_short_lo, evt_count, ev_exp); end
    n_cmp++; if ({s_baz, s_blrb, s_zz1pb, s_busy, s_done, s_bar} !== 6'b001001 || s_turn !== TURN_W'(1) || evt_count_s !== 2'd3) begin
      n_err++; $display("FAIL stop_narrow: got ctl=%b turn=%0d evt=%0d want 001001/1/3",
                        {s_baz, s_blrb, s_zz1pb, s_busy, s_done, s_bar}, s_turn, evt_count_s); end
  endtask

  task automatic test_zero_turn();
    clear_stats();
    do_start(0, 1'b1, 2, 3);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || cnt_baz !== 1'b0 || evt_count !== '0) begin
      n_err++; $display("FAIL zero_turn_finish: got done=%b busy=%b baz=%b evt=%0d want 1/1/0/0", done, busy, cnt_baz, evt_count); end
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || n_baz != 0 || n_done != 1) begin
      n_err++; $display("FAIL zero_turn_idle: got done=%b busy=%b loads=%0d dones=%0d want 0/0/0/1", done, busy, n_baz, n_done); end
  endtask

  task automatic test_start_stop_idle();
    clear_stats();
    cfg_turn = TURN_W'(7); cfg_events = EVT_W'(1);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || n_baz != 0 || cnt_turn !== '0 || cnt_zz1pb !== 1'b1) begin
      n_err++; $display("FAIL start_stop_idle: got busy=%b loads=%0d turn=%0d zz1pb=%b want 0/0/0/1", busy, n_baz, cnt_turn, cnt_zz1pb); end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 8; it++) begin
      int unsigned t, p, e;
      bit b;
      t = $urandom_range(4, 1); p = $urandom_range(3, 0); e = $urandom_range(3, 1); b = 1'($urandom_range(1, 0));
      clear_stats();
      do_start(t, b, e, p);
      wait_done(1000, ok);
      n_cmp++;
      if (!ok || n_done != 1 || evt_count !== EVT_W'(e) || n_baz != (b ? 1 : int'(e)) || n_ack_ep != int'(e) ||
          n_short_lo != 0 || gap_bad != 0 || blrb_bad != 0 || busy !== 1'b0 || cnt_turn !== TURN_W'(t) || cnt_bar !== b) begin
        n_err++;
        $display("FAIL random_%0d (t=%0d p=%0d e=%0d b=%0d): got done=%0d evt=%0d loads=%0d acks=%0d short=%0d gap_bad=%0d blrb_bad=%0d busy=%b turn=%0d bar=%b want 1/%0d/%0d/%0d/0/0/0/0/%0d/%0d",
                 it, t, p, e, b, n_done, evt_count, n_baz, n_ack_ep, n_short_lo, gap_bad, blrb_bad, busy, cnt_turn, cnt_bar,
                 e, (b ? 1 : e), e, t, b);
      end
      step();
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_stop();
    test_zero_turn();
    test_start_stop_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
